// File: rtl/alu_mac_sequencer.sv
// Neuron MAC sequencer: drives the shared combinational ALU to compute
// y = act(sum x[i]*w[i] + bias) one element every three cycles.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; latches len/bias/relu_en, clears acc/idx
// S_FETCH | presents idx on the operand memory address
// S_MUL   | x_data*w_data through the ALU, result captured in prod
// S_ACC   | acc + prod through the ALU; advances idx or leaves the loop
// S_BIAS  | acc + bias through the ALU
// S_ACT   | optional ReLU, result registered into y_out
// S_DONE  | one-cycle done pulse
module alu_mac_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_len,
  input  logic [DATA_W-1:0] i_bias,
  input  logic              i_relu_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_x_data,
  input  logic [DATA_W-1:0] i_w_data,
  output logic [DATA_W-1:0] o_alu_op1,
  output logic [DATA_W-1:0] o_alu_op2,
  output logic              o_alu_en,
  output logic [1:0]        o_alu_sel,
  input  logic [DATA_W-1:0] i_alu_result,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_y_out
);

  localparam logic [1:0] SEL_ADD  = 2'b00;
  localparam logic [1:0] SEL_MULT = 2'b10;
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_MUL, S_ACC, S_BIAS, S_ACT, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_prod;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W:0]     r_len;
  logic [DATA_W-1:0]   r_bias;
  logic                r_relu;
  logic [DATA_W-1:0]   r_y;
  logic [ADDR_W-1:0]   r_addr;
  logic                w_last;

  // idx is widened so len = 2**ADDR_W ends at idx = 2**ADDR_W-1 without wrapping
  assign w_last  = ({1'b0, r_idx} == (r_len - LEN_ONE));
  assign o_y_out = r_y;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and ALU/handshake outputs, all decoded from the current state
  always_comb begin
    w_next     = r_state;
    o_alu_op1  = '0;
    o_alu_op2  = '0;
    o_alu_en   = 1'b0;
    o_alu_sel  = SEL_ADD;
    o_busy     = (r_state != S_IDLE);
    o_done     = 1'b0;
    o_mem_addr = r_addr;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = (i_len != '0) ? S_FETCH : S_BIAS;
      end
      S_FETCH: begin
        o_mem_addr = r_idx;
        w_next     = S_MUL;
      end
      S_MUL: begin
        o_alu_op1 = i_x_data;
        o_alu_op2 = i_w_data;
        o_alu_sel = SEL_MULT;
        o_alu_en  = 1'b1;
        w_next    = S_ACC;
      end
      S_ACC: begin
        o_alu_op1 = r_acc;
        o_alu_op2 = r_prod;
        o_alu_en  = 1'b1;
        w_next    = w_last ? S_BIAS : S_FETCH;
      end
      S_BIAS: begin
        o_alu_op1 = r_acc;
        o_alu_op2 = r_bias;
        o_alu_en  = 1'b1;
        w_next    = S_ACT;
      end
      S_ACT:  w_next = S_DONE;
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers: operand latch, accumulator, index, address hold, result
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc  <= '0;
      r_prod <= '0;
      r_idx  <= '0;
      r_len  <= '0;
      r_bias <= '0;
      r_relu <= 1'b0;
      r_y    <= '0;
      r_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_len  <= i_len;
            r_bias <= i_bias;
            r_relu <= i_relu_en;
            r_acc  <= '0;
            r_idx  <= '0;
          end
        end
        S_FETCH: r_addr <= r_idx;
        S_MUL:   r_prod <= i_alu_result;
        S_ACC: begin
          r_acc <= i_alu_result;
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        S_BIAS: r_acc <= i_alu_result;
        S_ACT:  r_y   <= (r_relu && r_acc[DATA_W-1]) ? '0 : r_acc;
        default: ;
      endcase
    end
  end

endmodule
